// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encoding, line idle level and bit-rate constants.
package uart_pkg;

  // Serializer states: idle line, start bit, eight data bits, stop bit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Idle (mark) level of the serial line
  localparam logic LINE_IDLE = 1'b1;

  // Smallest usable clocks-per-bit; lower requests are clamped up to this
  localparam int CPB_MIN = 2;

  // 115200 baud from a 100 MHz clock
  localparam int CPB_115200_100M = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered occupancy count. The head entry
// is presented continuously on rd_data so a consumer can take it on the same
// edge that pops it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the registered count, so a write while full is
  // refused even if a pop frees a slot on the same edge.
  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset because pointers define validity
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO through a valid/ready
// port and are serialised LSB first. Consecutive queued bytes go out
// back-to-back with no idle gap between stop and start bits.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CPB_W      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CPB_W-1:0]            clks_per_bit,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_serial,
  output logic                        tx_active,
  output logic                        tx_done
);

  localparam logic [CPB_W-1:0] CPB_MIN_W = CPB_W'(CPB_MIN);

  tx_state_t        state_reg;
  logic [7:0]       shift_reg;
  logic [CPB_W-1:0] cpb_reg;
  logic [CPB_W-1:0] bit_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic             tx_serial_reg;
  logic             tx_active_reg;
  logic             tx_done_reg;
  logic             overflow_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [7:0]       fifo_rd_data;
  logic [CPB_W-1:0] cpb_eff;
  logic             bit_tc;

  // Clamp tiny bit periods; the result is only sampled when a byte is popped
  assign cpb_eff  = (clks_per_bit < CPB_MIN_W) ? CPB_MIN_W : clks_per_bit;
  assign bit_tc   = (bit_cnt_reg == cpb_reg - CPB_W'(1));
  // Pop when idle, or at the final stop-bit cycle to chain the next frame
  assign fifo_pop = !fifo_empty &&
                    ((state_reg == IDLE) || ((state_reg == STOP) && bit_tc));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (wr_valid),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign wr_ready  = !fifo_full;
  assign overflow  = overflow_reg;
  assign tx_serial = tx_serial_reg;
  assign tx_active = tx_active_reg;
  assign tx_done   = tx_done_reg;

  // Flag a write attempt that the full FIFO refused, one cycle later
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= wr_valid && fifo_full;
    end
  end

  // Serializer FSM; the line register follows the state one cycle behind
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cpb_reg       <= CPB_MIN_W;
      bit_cnt_reg   <= '0;
      bit_idx_reg   <= '0;
      tx_serial_reg <= LINE_IDLE;
      tx_active_reg <= 1'b0;
      tx_done_reg   <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tx_serial_reg <= LINE_IDLE;
          if (!fifo_empty) begin
            shift_reg     <= fifo_rd_data;
            cpb_reg       <= cpb_eff;
            bit_cnt_reg   <= '0;
            state_reg     <= START;
            tx_active_reg <= 1'b1;
          end
        end
        START: begin
          tx_serial_reg <= 1'b0;
          if (bit_tc) begin
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CPB_W'(1);
          end
        end
        DATA: begin
          tx_serial_reg <= shift_reg[bit_idx_reg];
          if (bit_tc) begin
            bit_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CPB_W'(1);
          end
        end
        STOP: begin
          tx_serial_reg <= LINE_IDLE;
          if (bit_tc) begin
            tx_done_reg <= 1'b1;
            bit_cnt_reg <= '0;
            if (!fifo_empty) begin
              shift_reg <= fifo_rd_data;
              cpb_reg   <= cpb_eff;
              state_reg <= START;
            end else begin
              state_reg     <= IDLE;
              tx_active_reg <= 1'b0;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CPB_W'(1);
          end
        end
        default: begin
          state_reg     <= IDLE;
          tx_active_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: accepts bytes through a valid/ready write port into an internal FIFO and serialises them 8N1, LSB first, on the PC-facing TX line. It sits between RX-side byte producers (echo path, future AES core) and the serial pin. It absorbs bursts that arrive faster than one byte per 10 bit-times, which a bare serializer would drop. Bit rate is set at run time by a clocks-per-bit input; 868 gives 115200 baud at 100 MHz.

## Interface
- FIFO_DEPTH, 16, byte FIFO entries; power of two, minimum 2
- CPB_W, 16, width of clks_per_bit
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clock
- clks_per_bit  in  CPB_W  clock cycles per serial bit; values 0 and 1 are treated as 2
- wr_valid  in  1  write request
- wr_data  in  8  byte to transmit
- wr_ready  out  1  FIFO not full; a write completes when wr_valid && wr_ready at a rising edge
- overflow  out  1  one-cycle pulse when wr_valid is high while wr_ready is low; that byte is dropped
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted
- tx_serial  out  1  serial line; idles high
- tx_active  out  1  high while a frame is on the line
- tx_done  out  1  one-cycle pulse at the end of each stop bit

## Operation
- Reset values: tx_serial=1, tx_active=0, tx_done=0, wr_ready=1, overflow=0, fifo_count=0. FIFO pointers are cleared.
- FIFO: circular buffer with wrap-around read and write pointers. fifo_count is a registered occupancy.
- Simultaneous push and pop leaves fifo_count unchanged.
- wr_ready is computed from the count before any same-cycle pop. A write while full is dropped even if a pop happens on the same edge.
- Serializer FSM states:
  - IDLE: tx_serial=1. If the FIFO is non-empty, pop one byte, latch it into the shift register, latch the effective CPB, go to START.
  - START: tx_serial=0 for CPB cycles, then go to DATA.
  - DATA: shift out bits 0..7, each for CPB cycles. A 3-bit index advances on each bit-counter terminal count. After bit 7, go to STOP.
  - STOP: tx_serial=1 for CPB cycles. At terminal count, pulse tx_done. If the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Effective CPB is max(clks_per_bit, 2). It is latched only at pop, so changing clks_per_bit mid-frame affects only the next byte.
- The bit counter counts 0..CPB-1 and is CPB_W bits wide. No arithmetic overflow is possible.
- tx_active = (state != IDLE), registered.
- tx_serial is registered. There are no combinational paths from inputs to tx_serial.
- Reset mid-frame: the line returns high at the next edge and all queued bytes are discarded. No partial-frame completion.

## Timing
- Byte written into an empty FIFO with the FSM idle at edge k: fifo_count=1 after k. Pop at k+1, where fifo_count returns to 0, state=START, tx_active=1. tx_serial goes low after edge k+2.
- Frame length is exactly 10*CPB cycles from the tx_serial falling edge to the end of the stop bit.
- tx_done is high for the final cycle of the stop bit. With bytes queued, the next start bit begins on the following cycle.
- Back-to-back frame period is 10*CPB cycles.
- wr_ready falls on the edge that makes fifo_count = FIFO_DEPTH. It rises on the edge after the first subsequent pop.
- overflow is combinational-free: it is registered and asserted in the cycle after the offending write attempt.

## Structure
- Shared package uart_pkg: FSM state enum (IDLE, START, DATA, STOP), LINE_IDLE=1'b1, CPB_MIN=2, CPB_115200_100M=868.
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count). The serializer FSM stays in uart_tx_buffered.

## Test plan
- CPB=4, write 0xA5 once -> tx_serial low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), high 4 cycles. tx_done pulses once at cycle 40 of the frame.
- CPB=4, write 16 bytes 0x00..0x0F on consecutive cycles -> all accepted, fifo_count peaks at 15. Frames are back-to-back every 40 cycles with no idle high between stop and start. 16 tx_done pulses.
- CPB=4, write 18 bytes on consecutive cycles -> wr_ready low once full, overflow pulses for the dropped write. Exactly 17 bytes transmitted (16 queued plus 1 popped to the shifter) in order; the dropped byte never appears.
- Change clks_per_bit 4->8 during a frame of 0x3C -> current frame stays 40 cycles, the next queued byte takes 80 cycles.
- Assert reset during DATA bit 3 with 5 bytes queued -> tx_serial=1 and tx_active=0 after the edge, fifo_count=0, no tx_done, no further frames.
- clks_per_bit=0, write 0xFF -> frame is 20 cycles (CPB clamped to 2), tx_done pulses once.
